// File: rtl/ram_arb_pkg.sv
// Shared definitions for the two-requester RAM arbiter: default widths,
// FSM state type and a small owner-to-one-hot helper.
package ram_arb_pkg;

    localparam int IDX_W_DEF  = 52;
    localparam int DATA_W_DEF = 128;
    localparam int MASK_W_DEF = DATA_W_DEF / 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    function automatic logic [1:0] onehot_of(input logic id);
        return id ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant: when both requesters are valid the pointer
// decides, otherwise the only valid requester wins.
module rr_arbiter2 (
    input  logic [1:0] valid,
    input  logic       ptr,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        if (valid == 2'b11) begin
            grant = ptr ? 2'b10 : 2'b01;
        end else begin
            grant = valid;
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Serialises two requesters onto a single combinational-read RAM model,
// one transaction in flight, round-robin fairness between requesters.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter  int IDX_W  = IDX_W_DEF,
    parameter  int DATA_W = DATA_W_DEF,
    localparam int MASK_W = DATA_W / 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            req_valid,
    output logic [1:0]            req_ready,
    input  logic [1:0]            req_wen,
    input  logic [2*IDX_W-1:0]    req_idx,
    input  logic [2*DATA_W-1:0]   req_wdata,
    input  logic [2*MASK_W-1:0]   req_wmask,
    output logic [1:0]            resp_valid,
    input  logic [1:0]            resp_ready,
    output logic [DATA_W-1:0]     resp_rdata,
    output logic                  ram_en,
    output logic                  ram_wen,
    output logic [IDX_W-1:0]      ram_rIdx,
    output logic [IDX_W-1:0]      ram_wIdx,
    output logic [DATA_W-1:0]     ram_wdata,
    output logic [MASK_W-1:0]     ram_wmask,
    input  logic [DATA_W-1:0]     ram_rdata
);

    state_t              state;
    state_t              state_nx;
    logic                ptr;
    logic                owner;
    logic                lat_wen;
    logic [IDX_W-1:0]    lat_idx;
    logic [DATA_W-1:0]   lat_wdata;
    logic [MASK_W-1:0]   lat_wmask;
    logic [DATA_W-1:0]   resp_data;
    logic [1:0]          grant;
    logic                handshake;
    logic                resp_done;

    rr_arbiter2 u_rr (
        .valid (req_valid),
        .ptr   (ptr),
        .grant (grant)
    );

    // grant is always a subset of req_valid, so any grant bit is a handshake.
    assign handshake  = (state == ST_IDLE) && (grant != 2'b00);
    assign resp_done  = (state == ST_RESP) && resp_ready[owner];
    assign resp_rdata = resp_data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        req_ready  = 2'b00;
        resp_valid = 2'b00;
        ram_en     = 1'b0;
        ram_wen    = 1'b0;
        ram_rIdx   = '0;
        ram_wIdx   = '0;
        ram_wdata  = '0;
        ram_wmask  = '0;
        case (state)
            ST_IDLE: begin
                req_ready = reset ? 2'b00 : grant;
                if (handshake) begin
                    state_nx = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                ram_en    = 1'b1;
                ram_wen   = lat_wen;
                ram_rIdx  = lat_idx;
                ram_wIdx  = lat_idx;
                ram_wdata = lat_wdata;
                ram_wmask = lat_wmask;
                state_nx  = ST_RESP;
            end
            ST_RESP: begin
                resp_valid = onehot_of(owner);
                if (resp_ready[owner]) begin
                    state_nx = ST_IDLE;
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    // Writes are acknowledged with zero data so both kinds share one response path.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr       <= 1'b0;
            owner     <= 1'b0;
            lat_wen   <= 1'b0;
            lat_idx   <= '0;
            lat_wdata <= '0;
            lat_wmask <= '0;
            resp_data <= '0;
        end else begin
            if (handshake) begin
                owner     <= grant[1];
                lat_wen   <= req_wen[grant[1]];
                lat_idx   <= req_idx[grant[1]*IDX_W +: IDX_W];
                lat_wdata <= req_wdata[grant[1]*DATA_W +: DATA_W];
                lat_wmask <= req_wmask[grant[1]*MASK_W +: MASK_W];
            end
            if (state == ST_ACCESS) begin
                resp_data <= lat_wen ? '0 : ram_rdata;
            end
            if (resp_done) begin
                ptr <= ~owner;
            end
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: RAM model with byte-masked writes,
// shadow memory for expectations and a response scoreboard queue.
module tb_ram_arbiter;
    import ram_arb_pkg::*;

    localparam int IDX_W  = 52;
    localparam int DATA_W = 128;
    localparam int MASK_W = DATA_W / 8;
    localparam logic [DATA_W-1:0] DEF_WORD = {16{8'hA5}};

    logic                  clk;
    logic                  reset;
    logic [1:0]            req_valid;
    logic [1:0]            req_ready;
    logic [1:0]            req_wen;
    logic [2*IDX_W-1:0]    req_idx;
    logic [2*DATA_W-1:0]   req_wdata;
    logic [2*MASK_W-1:0]   req_wmask;
    logic [1:0]            resp_valid;
    logic [1:0]            resp_ready;
    logic [DATA_W-1:0]     resp_rdata;
    logic                  ram_en;
    logic                  ram_wen;
    logic [IDX_W-1:0]      ram_rIdx;
    logic [IDX_W-1:0]      ram_wIdx;
    logic [DATA_W-1:0]     ram_wdata;
    logic [MASK_W-1:0]     ram_wmask;
    logic [DATA_W-1:0]     ram_rdata;

    typedef struct {
        logic [1:0]        owner;
        logic [DATA_W-1:0] rdata;
    } exp_t;

    exp_t sb[$];
    logic [DATA_W-1:0] ram_mem [logic [IDX_W-1:0]];
    logic [DATA_W-1:0] shadow  [logic [IDX_W-1:0]];
    int n_cmp;
    int n_err;

    ram_arbiter #(.IDX_W(IDX_W), .DATA_W(DATA_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_wen    (req_wen),
        .req_idx    (req_idx),
        .req_wdata  (req_wdata),
        .req_wmask  (req_wmask),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .ram_en     (ram_en),
        .ram_wen    (ram_wen),
        .ram_rIdx   (ram_rIdx),
        .ram_wIdx   (ram_wIdx),
        .ram_wdata  (ram_wdata),
        .ram_wmask  (ram_wmask),
        .ram_rdata  (ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] ram_read(input logic en, input logic [IDX_W-1:0] idx);
        if (!en) return '0;
        return ram_mem.exists(idx) ? ram_mem[idx] : DEF_WORD;
    endfunction

    function automatic logic [DATA_W-1:0] shadow_read(input logic [IDX_W-1:0] idx);
        return shadow.exists(idx) ? shadow[idx] : DEF_WORD;
    endfunction

    assign ram_rdata = ram_read(ram_en, ram_rIdx);

    always @(posedge clk) begin
        logic [DATA_W-1:0] w;
        if (ram_en && ram_wen) begin
            w = ram_mem.exists(ram_wIdx) ? ram_mem[ram_wIdx] : DEF_WORD;
            for (int b = 0; b < MASK_W; b++)
                if (ram_wmask[b]) w[b*8 +: 8] = ram_wdata[b*8 +: 8];
            ram_mem[ram_wIdx] = w;
        end
    end

    task automatic shadow_write(input logic [IDX_W-1:0] idx, input logic [DATA_W-1:0] d,
                                input logic [MASK_W-1:0] m);
        logic [DATA_W-1:0] w;
        w = shadow_read(idx);
        for (int b = 0; b < MASK_W; b++)
            if (m[b]) w[b*8 +: 8] = d[b*8 +: 8];
        shadow[idx] = w;
    endtask

    task automatic set_req(input int i, input logic wen, input logic [IDX_W-1:0] idx,
                           input logic [DATA_W-1:0] wd, input logic [MASK_W-1:0] wm);
        req_valid[i]                   = 1'b1;
        req_wen[i]                     = wen;
        req_idx[i*IDX_W +: IDX_W]      = idx;
        req_wdata[i*DATA_W +: DATA_W]  = wd;
        req_wmask[i*MASK_W +: MASK_W]  = wm;
    endtask

    task automatic test_reset();
        reset      = 1'b1;
        resp_ready = 2'b11;
        set_req(0, 1'b0, 'h1, '0, '0);
        set_req(1, 1'b0, 'h2, '0, '0);
        @(negedge clk); #1;
        n_cmp++; if (req_ready !== 2'b00) begin n_err++; $display("[TB] FAIL reset_req_ready: got %b expected 00", req_ready); end
        n_cmp++; if (resp_valid !== 2'b00) begin n_err++; $display("[TB] FAIL reset_resp_valid: got %b expected 00", resp_valid); end
        n_cmp++; if (resp_rdata !== '0) begin n_err++; $display("[TB] FAIL reset_resp_rdata: got %h expected 0", resp_rdata); end
        n_cmp++; if ({ram_en, ram_wen} !== 2'b00) begin n_err++; $display("[TB] FAIL reset_ram_en_wen: got %b expected 00", {ram_en, ram_wen}); end
        req_valid = 2'b00;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk); #1;
        n_cmp++; if ({req_ready, resp_valid} !== 4'b0000) begin n_err++; $display("[TB] FAIL idle_after_reset: got %b expected 0000", {req_ready, resp_valid}); end
    endtask

    task automatic test_single_read();
        exp_t e;
        @(negedge clk);
        set_req(0, 1'b0, 'h10, '0, '0);
        #1;
        n_cmp++; if (req_ready !== 2'b01) begin n_err++; $display("[TB] FAIL read_grant: got %b expected 01", req_ready); end
        sb.push_back('{owner: 2'b01, rdata: shadow_read('h10)});
        @(negedge clk);
        req_valid = 2'b00;
        #1;
        n_cmp++; if ({ram_en, ram_wen} !== 2'b10) begin n_err++; $display("[TB] FAIL read_access_en: got %b expected 10", {ram_en, ram_wen}); end
        n_cmp++; if (ram_rIdx !== 52'h10) begin n_err++; $display("[TB] FAIL read_ridx: got %h expected 10", ram_rIdx); end
        n_cmp++; if (req_ready !== 2'b00) begin n_err++; $display("[TB] FAIL read_ready_busy: got %b expected 00", req_ready); end
        @(negedge clk); #1;
        e = sb.pop_front();
        n_cmp++; if (ram_en !== 1'b0) begin n_err++; $display("[TB] FAIL read_en_one_cycle: got %b expected 0", ram_en); end
        n_cmp++; if (resp_valid !== e.owner) begin n_err++; $display("[TB] FAIL read_resp_valid: got %b expected %b", resp_valid, e.owner); end
        n_cmp++; if (resp_rdata !== e.rdata) begin n_err++; $display("[TB] FAIL read_rdata: got %h expected %h", resp_rdata, e.rdata); end
        @(negedge clk); #1;
        n_cmp++; if (resp_valid !== 2'b00) begin n_err++; $display("[TB] FAIL read_resp_done: got %b expected 00", resp_valid); end
    endtask

    task automatic test_single_write();
        exp_t e;
        @(negedge clk);
        set_req(1, 1'b1, 'h20, 128'h1234, 16'hFFFF);
        #1;
        n_cmp++; if (req_ready !== 2'b10) begin n_err++; $display("[TB] FAIL write_grant: got %b expected 10", req_ready); end
        shadow_write('h20, 128'h1234, 16'hFFFF);
        sb.push_back('{owner: 2'b10, rdata: '0});
        @(negedge clk);
        req_valid = 2'b00;
        #1;
        n_cmp++; if ({ram_en, ram_wen} !== 2'b11) begin n_err++; $display("[TB] FAIL write_access_en: got %b expected 11", {ram_en, ram_wen}); end
        n_cmp++; if (ram_wIdx !== 52'h20) begin n_err++; $display("[TB] FAIL write_widx: got %h expected 20", ram_wIdx); end
        n_cmp++; if (ram_wmask !== 16'hFFFF) begin n_err++; $display("[TB] FAIL write_wmask: got %h expected ffff", ram_wmask); end
        n_cmp++; if (ram_wdata !== 128'h1234) begin n_err++; $display("[TB] FAIL write_wdata: got %h expected 1234", ram_wdata); end
        @(negedge clk); #1;
        e = sb.pop_front();
        n_cmp++; if (ram_wen !== 1'b0) begin n_err++; $display("[TB] FAIL write_wen_one_cycle: got %b expected 0", ram_wen); end
        n_cmp++; if (resp_valid !== e.owner) begin n_err++; $display("[TB] FAIL write_resp_valid: got %b expected %b", resp_valid, e.owner); end
        n_cmp++; if (resp_rdata !== e.rdata) begin n_err++; $display("[TB] FAIL write_rdata: got %h expected %h", resp_rdata, e.rdata); end
        @(negedge clk);
    endtask

    // Both requesters held valid from reset release; grants must alternate every 3 cycles.
    task automatic test_back_to_back();
        exp_t e;
        int grants = 0;
        int resps  = 0;
        int last   = 0;
        int cyc;
        logic [1:0] want;
        reset      = 1'b1;
        resp_ready = 2'b11;
        set_req(0, 1'b0, 'h20, '0, '0);
        set_req(1, 1'b0, 'h30, '0, '0);
        @(negedge clk);
        reset = 1'b0;
        for (cyc = 0; cyc < 60 && resps < 4; cyc++) begin
            #1;
            if (grants >= 4) req_valid = 2'b00;
            if (resp_valid !== 2'b00) begin
                if (sb.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("[TB] FAIL b2b_unexpected_resp: got %b expected no response", resp_valid);
                end else begin
                    e = sb.pop_front();
                    n_cmp++; if (resp_valid !== e.owner) begin n_err++; $display("[TB] FAIL b2b_resp_owner: got %b expected %b", resp_valid, e.owner); end
                    n_cmp++; if (resp_rdata !== e.rdata) begin n_err++; $display("[TB] FAIL b2b_rdata: got %h expected %h", resp_rdata, e.rdata); end
                end
                resps++;
            end
            if ((req_ready & req_valid) != 2'b00) begin
                want = (grants % 2 == 1) ? 2'b10 : 2'b01;
                n_cmp++; if (req_ready !== want) begin n_err++; $display("[TB] FAIL b2b_grant%0d: got %b expected %b", grants, req_ready, want); end
                if (grants > 0) begin
                    n_cmp++; if (cyc - last != 3) begin n_err++; $display("[TB] FAIL b2b_spacing%0d: got %0d expected 3", grants, cyc - last); end
                end
                last = cyc;
                sb.push_back('{owner: want, rdata: shadow_read(want[1] ? 52'h30 : 52'h20)});
                grants++;
            end
            @(negedge clk);
        end
        req_valid = 2'b00;
        n_cmp++; if (resps != 4) begin n_err++; $display("[TB] FAIL b2b_timeout: got %0d responses expected 4", resps); end
        sb.delete();
    endtask

    task automatic test_backpressure();
        exp_t e;
        @(negedge clk);
        resp_ready = 2'b00;
        set_req(0, 1'b0, 'h40, '0, '0);
        #1;
        n_cmp++; if (req_ready !== 2'b01) begin n_err++; $display("[TB] FAIL bp_grant: got %b expected 01", req_ready); end
        sb.push_back('{owner: 2'b01, rdata: shadow_read('h40)});
        @(negedge clk);
        req_valid  = 2'b00;
        set_req(1, 1'b0, 'h30, '0, '0);
        resp_ready = 2'b10;
        e = sb.pop_front();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk); #1;
            n_cmp++; if (resp_valid !== e.owner) begin n_err++; $display("[TB] FAIL bp_valid%0d: got %b expected %b", k, resp_valid, e.owner); end
            n_cmp++; if (resp_rdata !== e.rdata) begin n_err++; $display("[TB] FAIL bp_rdata%0d: got %h expected %h", k, resp_rdata, e.rdata); end
            n_cmp++; if ({req_ready, ram_en} !== 3'b000) begin n_err++; $display("[TB] FAIL bp_quiet%0d: got %b expected 000", k, {req_ready, ram_en}); end
        end
        req_valid  = 2'b00;
        resp_ready = 2'b11;
        #1;
        n_cmp++; if (resp_valid !== 2'b01) begin n_err++; $display("[TB] FAIL bp_release_cycle: got %b expected 01", resp_valid); end
        @(negedge clk); #1;
        n_cmp++; if ({resp_valid, req_ready} !== 4'b0000) begin n_err++; $display("[TB] FAIL bp_complete: got %b expected 0000", {resp_valid, req_ready}); end
    endtask

    task automatic test_reset_in_access();
        exp_t e;
        @(negedge clk);
        resp_ready = 2'b11;
        set_req(0, 1'b1, 'h50, {16{8'h3C}}, 16'hFFFF);
        @(negedge clk);
        req_valid = 2'b00;
        #1;
        n_cmp++; if (ram_en !== 1'b1) begin n_err++; $display("[TB] FAIL rst_mid_access: got %b expected 1", ram_en); end
        reset = 1'b1;
        #1;
        n_cmp++; if ({ram_en, ram_wen, req_ready, resp_valid} !== 6'b0) begin n_err++; $display("[TB] FAIL rst_mid_ctrl: got %b expected 000000", {ram_en, ram_wen, req_ready, resp_valid}); end
        n_cmp++; if ((resp_rdata | ram_wdata) !== '0) begin n_err++; $display("[TB] FAIL rst_mid_data: got %h expected 0", resp_rdata | ram_wdata); end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); #1;
            n_cmp++; if (resp_valid !== 2'b00) begin n_err++; $display("[TB] FAIL rst_stale_resp%0d: got %b expected 00", k, resp_valid); end
        end
        set_req(0, 1'b0, 'h10, '0, '0);
        set_req(1, 1'b0, 'h30, '0, '0);
        #1;
        n_cmp++; if (req_ready !== 2'b01) begin n_err++; $display("[TB] FAIL rst_ptr_zero: got %b expected 01", req_ready); end
        req_valid[1] = 1'b0;
        sb.push_back('{owner: 2'b01, rdata: shadow_read('h10)});
        @(negedge clk);
        req_valid = 2'b00;
        @(negedge clk); #1;
        e = sb.pop_front();
        n_cmp++; if (resp_valid !== e.owner) begin n_err++; $display("[TB] FAIL rst_new_valid: got %b expected %b", resp_valid, e.owner); end
        n_cmp++; if (resp_rdata !== e.rdata) begin n_err++; $display("[TB] FAIL rst_new_rdata: got %h expected %h", resp_rdata, e.rdata); end
        @(negedge clk);
    endtask

    initial begin
        n_cmp      = 0;
        n_err      = 0;
        reset      = 1'b1;
        req_valid  = '0;
        req_wen    = '0;
        req_idx    = '0;
        req_wdata  = '0;
        req_wmask  = '0;
        resp_ready = '0;
        test_reset();
        test_single_read();
        test_single_write();
        test_back_to_back();
        test_backpressure();
        test_reset_in_access();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
